// File: rtl/ifu_fetch_pkg.sv
// Shared fetch-stage definitions: instruction width, NOP encoding, reset PC
// and the {inst, pc, snpc} entry carried from fetch to decode.
package ifu_fetch_pkg;

  localparam int          INST_W           = 32;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [31:0]       pc;
    logic [31:0]       snpc;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO with registered storage; flush overrides push and pop.
// The head is read straight from a storage register, never from din.
module ifu_fifo #(
  parameter  int WIDTH = 96,
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CNT_W'(DEPTH));
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !flush && !reset) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/ifu_fetch.sv
// RV32I instruction fetch: owns the fetch PC, streams word reads from a
// 1-cycle ROM into a small buffer and hands {inst, pc, snpc} to decode.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_ren,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        ready_next,
  output logic        valid_next,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic [31:0] snpc_out
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int OCC_W = CNT_W + 1;

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      req_pc_q, req_pc_d;
  logic             pending_q, pending_d;
  logic             drop_q, drop_d;

  logic             issue;
  logic             pop;
  logic             push;
  logic [OCC_W-1:0] occ;
  fetch_entry_t     push_entry;
  fetch_entry_t     head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;

  ifu_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (push_entry),
    .dout  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    valid_next = ~fifo_empty;
    inst_out   = fifo_empty ? NOP_INST : head.inst;
    pc_out     = fifo_empty ? 32'h0    : head.pc;
    snpc_out   = fifo_empty ? 32'h0    : head.snpc;

    pop   = valid_next & ready_next & ~redirect_valid;
    occ   = OCC_W'(fifo_count) + OCC_W'(pending_q);
    issue = ~reset & ~redirect_valid & ((occ < OCC_W'(FIFO_DEPTH)) | pop);

    imem_ren  = issue;
    imem_addr = fetch_pc_q;

    push            = pending_q & ~drop_q;
    push_entry.inst = imem_rdata;
    push_entry.pc   = req_pc_q;
    push_entry.snpc = req_pc_q + 32'd4;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    pending_d  = issue;
    drop_d     = drop_q;

    if (pending_q && drop_q) drop_d = 1'b0;

    if (issue) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
      req_pc_d   = fetch_pc_q;
    end

    // The response landing this cycle dies in the flush; only a request still
    // outstanding after the redirect would need its data dropped.
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      drop_d     = pending_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      pending_q  <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pending_q  <= pending_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge clock) begin
    req_pc_q <= req_pc_d;
  end

  always_ff @(posedge clock) begin
    if (!reset) assert (occ <= OCC_W'(FIFO_DEPTH) && !(fifo_full && pending_q));
  end

endmodule
